// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw active-low pins in, clean levels and
// single-cycle event pulses out. The conditioner uses the slave view; the pad
// side / consumer uses the master view.
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw_n;
  logic [N_BTN-1:0] btn_db_n;
  logic [N_BTN-1:0] press_p;
  logic [N_BTN-1:0] release_p;
  logic [N_BTN-1:0] hold_p;

  modport master (
    output btn_raw_n,
    input  btn_db_n,
    input  press_p,
    input  release_p,
    input  hold_p
  );

  modport slave (
    input  btn_raw_n,
    output btn_db_n,
    output press_p,
    output release_p,
    output hold_p
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel synchroniser, debouncer, edge detector and hold detector for
// active-low push buttons. Every channel is an independent copy of the same
// logic; all outputs come straight from flops.
module button_conditioner #(
  parameter int N_BTN       = 4,
  parameter int DB_CYCLES   = 60000,
  parameter int HOLD_CYCLES = 3000000
) (
  input  logic          clk,
  input  logic          rst_n,
  button_conditioner_if.slave bus
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    REL  = 2'd0,
    PRS  = 2'd1,
    HELD = 2'd2
  } hold_state_t;

  logic [N_BTN-1:0] db_v_s;
  logic [N_BTN-1:0] press_v_s;
  logic [N_BTN-1:0] release_v_s;
  logic [N_BTN-1:0] hold_v_s;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          sync1_r;
    logic          s_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic          db_r;
    logic          db_nx_s;
    logic          accept_s;
    logic          press_ev_s;
    logic          release_ev_s;
    logic          press_r;
    logic          release_r;
    hold_state_t   state_r;
    hold_state_t   state_nx_s;
    logic [HW-1:0] hcnt_r;
    logic [HW-1:0] hcnt_nx_s;
    logic          hold_nx_s;
    logic          hold_r;

    // Two-stage synchroniser for the asynchronous pin; idles released (1).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_r <= 1'b1;
        s_r     <= 1'b1;
      end else begin
        sync1_r <= bus.btn_raw_n[i];
        s_r     <= sync1_r;
      end
    end

    // Debounce: count consecutive cycles of disagreement; any agreement restarts.
    always_comb begin
      cnt_nx_s = cnt_r;
      db_nx_s  = db_r;
      accept_s = 1'b0;
      if (s_r == db_r) begin
        cnt_nx_s = {CW{1'b0}};
      end else if (cnt_r == DB_LAST) begin
        cnt_nx_s = {CW{1'b0}};
        db_nx_s  = s_r;
        accept_s = 1'b1;
      end else begin
        cnt_nx_s = cnt_r + CW'(1);
      end
    end

    assign press_ev_s   = accept_s & ~s_r;
    assign release_ev_s = accept_s & s_r;

    // Debounced level plus press/release pulses, updated on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r     <= {CW{1'b0}};
        db_r      <= 1'b1;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        cnt_r     <= cnt_nx_s;
        db_r      <= db_nx_s;
        press_r   <= press_ev_s;
        release_r <= release_ev_s;
      end
    end

    // Hold FSM next state: one hold pulse per press; a release always wins.
    always_comb begin
      state_nx_s = state_r;
      hcnt_nx_s  = hcnt_r;
      hold_nx_s  = 1'b0;
      case (state_r)
        REL: begin
          if (press_ev_s) begin
            state_nx_s = PRS;
            hcnt_nx_s  = {HW{1'b0}};
          end else begin
            state_nx_s = REL;
          end
        end
        PRS: begin
          if (release_ev_s) begin
            state_nx_s = REL;
            hcnt_nx_s  = {HW{1'b0}};
          end else if (hcnt_r == HOLD_LAST) begin
            state_nx_s = HELD;
            hold_nx_s  = 1'b1;
          end else begin
            hcnt_nx_s  = hcnt_r + HW'(1);
          end
        end
        HELD: begin
          if (release_ev_s) begin
            state_nx_s = REL;
            hcnt_nx_s  = {HW{1'b0}};
          end else begin
            state_nx_s = HELD;
          end
        end
        default: begin
          state_nx_s = REL;
          hcnt_nx_s  = {HW{1'b0}};
        end
      endcase
    end

    // Hold FSM state, counter and registered hold pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= REL;
        hcnt_r  <= {HW{1'b0}};
        hold_r  <= 1'b0;
      end else begin
        state_r <= state_nx_s;
        hcnt_r  <= hcnt_nx_s;
        hold_r  <= hold_nx_s;
      end
    end

    assign db_v_s[i]      = db_r;
    assign press_v_s[i]   = press_r;
    assign release_v_s[i] = release_r;
    assign hold_v_s[i]    = hold_r;
  end

  assign bus.btn_db_n  = db_v_s;
  assign bus.press_p   = press_v_s;
  assign bus.release_p = release_v_s;
  assign bus.hold_p    = hold_v_s;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios plus a random phase,
// every cycle compared against a window-based reference model.
module tb_button_conditioner;
  localparam int N    = 4;
  localparam int DB   = 8;
  localparam int HOLD = 32;

  logic       clk;
  logic       rst_n;
  logic [3:0] pin;
  int         total;
  int         bad;
  int         n;

  // reference model state
  logic [3:0]    m_sync1;
  logic [3:0]    m_db;
  logic [3:0]    e_press;
  logic [3:0]    e_rel;
  logic [3:0]    e_hold;
  logic [DB-1:0] s_win [N];
  int            s_cnt [N];
  int            press_edge [N];

  // observed pulse counters
  int c_press [N];
  int c_rel   [N];
  int c_hold  [N];

  button_conditioner_if #(.N_BTN(N)) bus ();

  button_conditioner #(.N_BTN(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.btn_raw_n = pin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @edge%0d obs=%h exp=%h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync1 = 4'hF;
    m_db    = 4'hF;
    e_press = 4'h0;
    e_rel   = 4'h0;
    e_hold  = 4'h0;
    for (int c = 0; c < N; c++) begin
      s_win[c]      = '1;
      s_cnt[c]      = 0;
      press_edge[c] = -100000;
    end
  endtask

  // A level is accepted once the synchronised pin has shown the opposite value
  // for the last DB edges in a row (history restarts at reset).
  task automatic model_step();
    n++;
    e_press = 4'h0;
    e_rel   = 4'h0;
    e_hold  = 4'h0;
    if (rst_n !== 1'b1) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) begin
      logic [DB-1:0] want;
      want = m_db[c] ? {DB{1'b0}} : {DB{1'b1}};
      if (s_cnt[c] == DB && s_win[c] == want) begin
        m_db[c] = ~m_db[c];
        if (m_db[c] == 1'b0) begin
          e_press[c]    = 1'b1;
          press_edge[c] = n;
        end else begin
          e_rel[c] = 1'b1;
        end
      end
      if (m_db[c] == 1'b0 && (n - press_edge[c]) == HOLD) e_hold[c] = 1'b1;
      s_win[c] = {s_win[c][DB-2:0], m_sync1[c]};
      if (s_cnt[c] < DB) s_cnt[c]++;
    end
    m_sync1 = pin;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("db",   bus.btn_db_n,  m_db);
    chk("prs",  bus.press_p,   e_press);
    chk("rel",  bus.release_p, e_rel);
    chk("hold", bus.hold_p,    e_hold);
    for (int c = 0; c < N; c++) begin
      if (bus.press_p[c]   === 1'b1) c_press[c]++;
      if (bus.release_p[c] === 1'b1) c_rel[c]++;
      if (bus.hold_p[c]    === 1'b1) c_hold[c]++;
    end
  endtask

  task automatic ticks(int k);
    for (int j = 0; j < k; j++) tick();
  endtask

  task automatic clr_counts();
    for (int c = 0; c < N; c++) begin
      c_press[c] = 0;
      c_rel[c]   = 0;
      c_hold[c]  = 0;
    end
  endtask

  task automatic rst_pulse(int k);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_async_db",   bus.btn_db_n,  4'hF);
    chk("rst_async_prs",  bus.press_p,   4'h0);
    chk("rst_async_rel",  bus.release_p, 4'h0);
    chk("rst_async_hold", bus.hold_p,    4'h0);
    ticks(k);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n     = 0;
    pin   = 4'h0;
    rst_n = 1'b0;
    model_reset();
    clr_counts();

    // 1: reset with all pins pressed
    ticks(4);
    chk("t1_db_in_reset", bus.btn_db_n, 4'hF);
    pin = 4'hF;
    ticks(2);
    rst_n = 1'b1;
    ticks(12);

    // 2: clean press then release on ch0
    clr_counts();
    pin[0] = 1'b0;
    ticks(9);
    chk("t2_db0_early", bus.btn_db_n[0], 1'b1);
    chk("t2_prs0_early", bus.press_p[0], 1'b0);
    tick();
    chk("t2_db0", bus.btn_db_n[0], 1'b0);
    chk("t2_prs0", bus.press_p[0], 1'b1);
    tick();
    chk("t2_prs0_once", bus.press_p[0], 1'b0);
    ticks(39);
    pin[0] = 1'b1;
    ticks(9);
    chk("t2_rel0_early", bus.release_p[0], 1'b0);
    tick();
    chk("t2_rel0", bus.release_p[0], 1'b1);
    chk("t2_db0_back", bus.btn_db_n[0], 1'b1);
    tick();
    chk("t2_rel0_once", bus.release_p[0], 1'b0);
    ticks(5);

    // 3: bouncing press on ch1
    clr_counts();
    pin[1] = 1'b0; ticks(3);
    pin[1] = 1'b1; ticks(3);
    pin[1] = 1'b0; ticks(3);
    pin[1] = 1'b1; ticks(3);
    pin[1] = 1'b0;
    ticks(9);
    chk("t3_db1_early", bus.btn_db_n[1], 1'b1);
    chk("t3_no_early_prs", c_press[1], 0);
    tick();
    chk("t3_prs1", bus.press_p[1], 1'b1);
    ticks(10);
    chk("t3_one_press", c_press[1], 1);
    pin[1] = 1'b1;
    ticks(15);

    // 4: long hold then short press on ch2
    clr_counts();
    pin[2] = 1'b0;
    ticks(10);
    chk("t4_prs2", bus.press_p[2], 1'b1);
    ticks(31);
    chk("t4_hold2_early", bus.hold_p[2], 1'b0);
    tick();
    chk("t4_hold2", bus.hold_p[2], 1'b1);
    ticks(58);
    pin[2] = 1'b1;
    ticks(10);
    chk("t4_rel2", bus.release_p[2], 1'b1);
    ticks(5);
    chk("t4_one_press", c_press[2], 1);
    chk("t4_one_hold", c_hold[2], 1);
    clr_counts();
    pin[2] = 1'b0;
    ticks(20);
    pin[2] = 1'b1;
    ticks(50);
    chk("t4_short_press", c_press[2], 1);
    chk("t4_short_rel", c_rel[2], 1);
    chk("t4_short_nohold", c_hold[2], 0);

    // 5: all channels pressed on one edge
    pin = 4'h0;
    ticks(10);
    chk("t5_prs_all", bus.press_p, 4'hF);
    tick();
    chk("t5_prs_all_once", bus.press_p, 4'h0);
    pin = 4'hF;
    ticks(15);

    // 6: reset in the middle of a debounce on ch3 with the pin held
    clr_counts();
    pin[3] = 1'b0;
    ticks(7);
    rst_pulse(3);
    chk("t6_no_pulse_in_reset", c_press[3], 0);
    ticks(9);
    chk("t6_prs3_early", bus.press_p[3], 1'b0);
    tick();
    chk("t6_prs3", bus.press_p[3], 1'b1);
    pin[3] = 1'b1;
    ticks(15);

    // random phase: independent random run lengths per channel
    begin
      int run [N];
      for (int c = 0; c < N; c++) run[c] = int'($urandom_range(1, 60));
      for (int cyc = 0; cyc < 2000; cyc++) begin
        for (int c = 0; c < N; c++) begin
          run[c]--;
          if (run[c] <= 0) begin
            pin[c] = ~pin[c];
            run[c] = int'($urandom_range(1, 60));
          end
        end
        if (cyc == 900) rst_pulse(2);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
